// File: rtl/uart_pkg.sv
// uart_pkg: shared state type, frame constants and hex font for uart_full.
// UART_PARITY_EN selects the 11-bit 8E1 frame; left undefined the frame is 8N1.
package uart_pkg;

   localparam int DATA_BITS         = 8;
   localparam int CLKS_PER_BIT_DFLT = 434;

   // state  | meaning
   // IDLE   | line idle high; TX waits for launch, RX for a start edge
   // START  | start bit; RX re-checks the line at half a bit
   // DATA   | eight data bits, LSB first
   // PARITY | even-parity bit (parity builds only)
   // STOP   | stop bit; RX also waits here for the line after a framing error
`ifdef UART_PARITY_EN
   typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} uart_state_e;
`else
   typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_e;
`endif

   // gfedcba, active-low, digits 0..F
   localparam logic [6:0] SEG_FONT [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

endpackage

// File: rtl/seg7_hex.sv
// seg7_hex: one hex nibble to an active-low common-anode seven-segment pattern.
module seg7_hex
   import uart_pkg::*;
(
   input  logic [3:0] hex_i,
   output logic [6:0] seg_o
);

   assign seg_o = SEG_FONT[hex_i];

endmodule

// File: rtl/uart_full.sv
// uart_full: full-duplex 8-bit UART with receive strobe and two-digit hex readout.
// Build option UART_PARITY_EN: defined gives 8E1 frames, undefined gives 8N1.
module uart_full
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DFLT
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic [7:0]  TX_DATA,
   input  logic        tx_send,
   input  logic        rx,
   output logic        tx,
   output logic        parity_error,
   output logic        heard_bit_out,
   output logic [7:0]  RX_DATA,
   output logic [13:0] DISPLAYS
);

   localparam int            CW        = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [2:0]    IDX_LAST  = 3'(DATA_BITS - 1);

   uart_state_e   tx_state_q, tx_state_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]    tx_idx_q, tx_idx_d;
   logic [7:0]    tx_dat_q, tx_dat_d;
   logic          tx_send_q;
   logic          tx_q, tx_d;
   logic          tx_tc;

   uart_state_e   rx_state_q, rx_state_d;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]    rx_idx_q, rx_idx_d;
   logic [7:0]    rx_shr_q, rx_shr_d;
   logic          rx_ferr_q, rx_ferr_d;
   logic          rx_s1_q, rx_s2_q, rx_s3_q;
   logic [7:0]    rx_data_q, rx_data_d;
   logic          heard_q, heard_d;
   logic          rx_tc;
`ifdef UART_PARITY_EN
   logic          rx_par_q, rx_par_d;
   logic          perr_q, perr_d;
`endif

   always_ff @(posedge clk) begin
      if (n_rst) begin
         tx_state_q <= ST_IDLE;
         tx_cnt_q   <= '0;
         tx_idx_q   <= '0;
         tx_dat_q   <= '0;
         tx_send_q  <= 1'b1;
         tx_q       <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_idx_q   <= tx_idx_d;
         tx_dat_q   <= tx_dat_d;
         tx_send_q  <= tx_send;
         tx_q       <= tx_d;
      end
   end

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_idx_d   = tx_idx_q;
      tx_dat_d   = tx_dat_q;
      tx_d       = 1'b1;
      tx_tc      = (tx_cnt_q == '0);
      if (tx_state_q != ST_IDLE) begin
         tx_cnt_d = tx_tc ? BIT_LAST : tx_cnt_q - 1'b1;
      end
      unique case (tx_state_q)
         ST_IDLE: begin
            // launch on a falling edge of the request only
            if (tx_send_q && !tx_send) begin
               tx_state_d = ST_START;
               tx_cnt_d   = BIT_LAST;
               tx_dat_d   = TX_DATA;
            end
         end
         ST_START: begin
            tx_d = 1'b0;
            if (tx_tc) begin
               tx_state_d = ST_DATA;
               tx_idx_d   = '0;
            end
         end
         ST_DATA: begin
            tx_d = tx_dat_q[tx_idx_q];
            if (tx_tc) begin
               tx_idx_d = tx_idx_q + 1'b1;
               if (tx_idx_q == IDX_LAST) begin
`ifdef UART_PARITY_EN
                  tx_state_d = ST_PARITY;
`else
                  tx_state_d = ST_STOP;
`endif
               end
            end
         end
`ifdef UART_PARITY_EN
         ST_PARITY: begin
            tx_d = ^tx_dat_q;
            if (tx_tc) tx_state_d = ST_STOP;
         end
`endif
         ST_STOP: begin
            if (tx_tc) tx_state_d = ST_IDLE;
         end
         default: tx_state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (n_rst) begin
         rx_s1_q    <= 1'b1;
         rx_s2_q    <= 1'b1;
         rx_s3_q    <= 1'b1;
         rx_state_q <= ST_IDLE;
         rx_cnt_q   <= '0;
         rx_idx_q   <= '0;
         rx_shr_q   <= '0;
         rx_ferr_q  <= 1'b0;
         rx_data_q  <= '0;
         heard_q    <= 1'b0;
`ifdef UART_PARITY_EN
         rx_par_q   <= 1'b0;
         perr_q     <= 1'b0;
`endif
      end else begin
         rx_s1_q    <= rx;
         rx_s2_q    <= rx_s1_q;
         rx_s3_q    <= rx_s2_q;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_idx_q   <= rx_idx_d;
         rx_shr_q   <= rx_shr_d;
         rx_ferr_q  <= rx_ferr_d;
         rx_data_q  <= rx_data_d;
         heard_q    <= heard_d;
`ifdef UART_PARITY_EN
         rx_par_q   <= rx_par_d;
         perr_q     <= perr_d;
`endif
      end
   end

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_idx_d   = rx_idx_q;
      rx_shr_d   = rx_shr_q;
      rx_ferr_d  = rx_ferr_q;
      rx_data_d  = rx_data_q;
      heard_d    = 1'b0;
`ifdef UART_PARITY_EN
      rx_par_d   = rx_par_q;
      perr_d     = perr_q;
`endif
      rx_tc      = (rx_cnt_q == '0);
      if (rx_state_q != ST_IDLE) begin
         rx_cnt_d = rx_tc ? BIT_LAST : rx_cnt_q - 1'b1;
      end
      unique case (rx_state_q)
         ST_IDLE: begin
            if (rx_s3_q && !rx_s2_q) begin
               rx_state_d = ST_START;
               rx_cnt_d   = HALF_LAST;
            end
         end
         ST_START: begin
            if (rx_tc) begin
               rx_state_d = rx_s2_q ? ST_IDLE : ST_DATA;
               rx_idx_d   = '0;
            end
         end
         ST_DATA: begin
            if (rx_tc) begin
               rx_shr_d = {rx_s2_q, rx_shr_q[7:1]};
               rx_idx_d = rx_idx_q + 1'b1;
               if (rx_idx_q == IDX_LAST) begin
`ifdef UART_PARITY_EN
                  rx_state_d = ST_PARITY;
`else
                  rx_state_d = ST_STOP;
`endif
               end
            end
         end
`ifdef UART_PARITY_EN
         ST_PARITY: begin
            if (rx_tc) begin
               rx_par_d   = rx_s2_q;
               rx_state_d = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            // after a framing error, hold off until the line is back high
            if (rx_ferr_q) begin
               if (rx_s2_q) begin
                  rx_ferr_d  = 1'b0;
                  rx_state_d = ST_IDLE;
               end
            end else if (rx_tc) begin
               if (rx_s2_q) begin
                  rx_data_d  = rx_shr_q;
                  heard_d    = 1'b1;
                  rx_state_d = ST_IDLE;
`ifdef UART_PARITY_EN
                  perr_d     = rx_par_q ^ (^rx_shr_q);
`endif
               end else begin
                  rx_ferr_d = 1'b1;
               end
            end
         end
         default: rx_state_d = ST_IDLE;
      endcase
   end

   assign tx            = tx_q;
   assign heard_bit_out = heard_q;
   assign RX_DATA       = rx_data_q;
`ifdef UART_PARITY_EN
   assign parity_error  = perr_q;
`else
   assign parity_error  = 1'b0;
`endif

   seg7_hex u_seg_hi (.hex_i(rx_data_q[7:4]), .seg_o(DISPLAYS[13:7]));
   seg7_hex u_seg_lo (.hex_i(rx_data_q[3:0]), .seg_o(DISPLAYS[6:0]));

endmodule

// File: tb/tb_uart_full.sv
// tb_uart_full: directed stimulus with a timing-level frame model and a per-cycle compare.
// Works for both UART_PARITY_EN builds; frame length follows the macro.
module tb_uart_full;

   localparam int CPB = 8;
`ifdef UART_PARITY_EN
   localparam int NB  = 11;
   localparam bit PEN = 1'b1;
   localparam logic [10:0] LIT_AF = 11'b10101011110;
`else
   localparam int NB  = 10;
   localparam bit PEN = 1'b0;
   localparam logic [10:0] LIT_AF = 11'b01101011110;
`endif
   localparam logic [10:0] LIT_AE = 11'b11101011100;

   localparam logic [6:0] FONT [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   logic        clk = 1'b0;
   logic        n_rst, tx_send, rx, rx_drv, loop;
   logic [7:0]  TX_DATA;
   logic        tx, parity_error, heard_bit_out;
   logic [7:0]  RX_DATA;
   logic [13:0] DISPLAYS;

   assign rx = loop ? tx : rx_drv;
   always #5 clk = ~clk;

   uart_full #(.CLKS_PER_BIT(CPB)) dut (
      .clk(clk), .n_rst(n_rst), .TX_DATA(TX_DATA), .tx_send(tx_send), .rx(rx),
      .tx(tx), .parity_error(parity_error), .heard_bit_out(heard_bit_out),
      .RX_DATA(RX_DATA), .DISPLAYS(DISPLAYS)
   );

   typedef struct {
      logic [7:0] data;
      logic       perr;
      int         nom;
   } exp_t;

   exp_t       exp_q[$];
   int         errors = 0, checks = 0, pe = 0, strobes = 0;
   logic       m_live = 1'b0, m_busy = 1'b0, m_prev = 1'b1, m_have = 1'b0;
   int         m_launch = 0;
   logic [7:0] m_data = '0, m_rx_data = '0;
   logic       m_perr = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, pe);
      end
   endtask

   // bit idx of a frame: 0 start, 1..8 data LSB first, then parity (if any), then stop
   function automatic logic frame_bit(input logic [7:0] d, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return d[idx-1];
      if (PEN && idx == 9) return ^d;
      return 1'b1;
   endfunction

   // nominal strobe edge: 2 sync cycles + (frame-0.5) bit times after the falling edge
   function automatic void push_exp(input logic [7:0] d, input logic p, input int f);
      exp_t e;
      e.data = d;
      e.perr = p;
      e.nom  = f + 2 + (NB - 1) * CPB + CPB / 2;
      exp_q.push_back(e);
   endfunction

   // model: tracks launches, aborts and expected receptions in units of clock edges
   always @(posedge clk) begin
      pe = pe + 1;
      if (n_rst === 1'b1) begin
         m_live = 1'b1; m_busy = 1'b0; m_have = 1'b0; m_prev = 1'b1;
         exp_q.delete();
         m_rx_data = '0; m_perr = 1'b0;
      end else if (m_live) begin
         if (m_busy && pe > m_launch + NB * CPB) m_busy = 1'b0;
         if (!m_busy && m_prev && !tx_send) begin
            m_busy = 1'b1; m_have = 1'b1; m_launch = pe; m_data = TX_DATA;
            if (loop) push_exp(TX_DATA, 1'b0, pe + 1);
         end
         m_prev = tx_send;
      end
   end

   always @(negedge clk) begin : cmp_blk
      exp_t e;
      int   k;
      logic exp_tx;
      if (m_live) begin
         k = pe - m_launch - 1;
         exp_tx = (m_have && k >= 0 && k < NB * CPB) ? frame_bit(m_data, k / CPB) : 1'b1;
         chk("tx_line", tx, exp_tx);
         if (heard_bit_out === 1'b1) begin
            strobes++;
            if (exp_q.size() == 0) begin
               chk("unexpected_strobe", heard_bit_out, 0);
            end else begin
               e = exp_q.pop_front();
               chk("strobe_time_ok", (pe >= e.nom - 1 && pe <= e.nom + 1), 1);
               m_rx_data = e.data;
               m_perr    = e.perr;
            end
         end else begin
            chk("strobe_idle", heard_bit_out, 0);
            if (exp_q.size() > 0 && pe > exp_q[0].nom + 1) begin
               chk("missing_strobe", heard_bit_out, 1);
               void'(exp_q.pop_front());
            end
         end
         chk("rx_data", RX_DATA, m_rx_data);
         chk("parity_error", parity_error, m_perr);
         chk("displays", DISPLAYS, {FONT[m_rx_data[7:4]], FONT[m_rx_data[3:0]]});
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_pulse(output int l);
      tx_send = 1'b0;
      tick();
      l = pe;
      tx_send = 1'b1;
   endtask

   task automatic check_tx_bits(input int l, input logic [10:0] lit, input string tag);
      for (int b = 0; b < NB; b++) begin
         while (pe < l + 1 + b * CPB + CPB / 2) tick();
         chk($sformatf("%s_bit%0d", tag, b), tx, lit[b]);
      end
   endtask

   task automatic send_rx(input logic [7:0] d, input logic pbit, input logic stop);
      if (stop) push_exp(d, PEN ? (pbit ^ (^d)) : 1'b0, pe);
      rx_drv = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         rx_drv = d[i];
         tick(CPB);
      end
      if (PEN) begin
         rx_drv = pbit;
         tick(CPB);
      end
      rx_drv = stop;
      tick(CPB);
      rx_drv = 1'b1;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < 400) begin
         tick();
         n++;
      end
      if (n >= 400) chk("drain_timeout", exp_q.size(), 0);
      tick(4);
   endtask

   initial begin
      int l, s0;
      n_rst = 1'b1; tx_send = 1'b1; rx_drv = 1'b1; loop = 1'b1; TX_DATA = '0;
      tick(3);
      chk("rst_tx", tx, 1);
      chk("rst_rx_data", RX_DATA, 8'h00);
      chk("rst_displays", DISPLAYS, 14'h2040);
      chk("rst_heard", heard_bit_out, 0);
      n_rst = 1'b0;
      tick(2);

      TX_DATA = 8'hAE; s0 = strobes;
      send_pulse(l);
      check_tx_bits(l, LIT_AE, "ae");
      wait_drain();
      chk("ae_rx_data", RX_DATA, 8'hAE);
      chk("ae_perr", parity_error, 0);
      chk("ae_displays", DISPLAYS, {7'h08, 7'h06});
      chk("ae_strobes", strobes - s0, 1);

      TX_DATA = 8'hAF;
      n_rst = 1'b1; tick(2); n_rst = 1'b0; tick(2);
      chk("af_rst_rx_data", RX_DATA, 8'h00);
      s0 = strobes;
      send_pulse(l);
      check_tx_bits(l, LIT_AF, "af");
      wait_drain();
      chk("af_rx_data", RX_DATA, 8'hAF);
      chk("af_displays", DISPLAYS, {7'h08, 7'h0E});
      chk("af_strobes", strobes - s0, 1);

      loop = 1'b0; tick(2); s0 = strobes;
      send_rx(8'h55, 1'b1, 1'b1);
      wait_drain();
      chk("p55_rx_data", RX_DATA, 8'h55);
      chk("p55_perr", parity_error, PEN);
      chk("p55_strobes", strobes - s0, 1);

      loop = 1'b1; TX_DATA = 8'h3C; s0 = strobes;
      tx_send = 1'b0;
      tick(30 * CPB);
      tx_send = 1'b1;
      wait_drain();
      chk("hold_strobes", strobes - s0, 1);
      chk("hold_rx_data", RX_DATA, 8'h3C);

      loop = 1'b0; tick(2); s0 = strobes;
      rx_drv = 1'b0; tick(2); rx_drv = 1'b1;
      tick(20 * CPB);
      chk("glitch_strobes", strobes - s0, 0);
      chk("glitch_rx_data", RX_DATA, 8'h3C);
      s0 = strobes;
      send_rx(8'hC9, 1'b0, 1'b1);
      wait_drain();
      chk("c9_rx_data", RX_DATA, 8'hC9);
      chk("c9_perr", parity_error, 0);
      chk("c9_strobes", strobes - s0, 1);

      loop = 1'b1; TX_DATA = 8'h52; tick(2);
      send_pulse(l);
      while (pe < l + 1 + 4 * CPB + 3) tick();
      chk("abort_pre_tx", tx, 0);
      n_rst = 1'b1; tick(); 
      chk("abort_tx", tx, 1);
      n_rst = 1'b0; s0 = strobes;
      tick(12 * CPB);
      chk("abort_strobes", strobes - s0, 0);
      chk("abort_rx_data", RX_DATA, 8'h00);

      loop = 1'b0; tick(2);
      send_rx(8'h6B, 1'b1, 1'b1);
      wait_drain();
      chk("6b_rx_data", RX_DATA, 8'h6B);
      s0 = strobes;
      send_rx(8'h81, 1'b0, 1'b0);
      rx_drv = 1'b0; tick(2 * CPB); rx_drv = 1'b1;
      tick(4 * CPB);
      chk("ferr_strobes", strobes - s0, 0);
      chk("ferr_rx_data", RX_DATA, 8'h6B);
      s0 = strobes;
      send_rx(8'h24, 1'b0, 1'b1);
      wait_drain();
      chk("24_rx_data", RX_DATA, 8'h24);
      chk("24_displays", DISPLAYS, {7'h24, 7'h19});
      chk("24_strobes", strobes - s0, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached at edge %0d", pe);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/uart_full.md
# uart_full

Full-duplex 8-bit UART with an even-parity bit, a receive-byte strobe and a two-digit hex seven-segment readout of the last received byte. It is the board-level serial block. It sits between a push-button/switch front end (`TX_DATA`, `tx_send`) and the serial pins (`tx`, `rx`), with `DISPLAYS` driving two common-anode digits.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per bit, which is 115200 baud at 50 MHz. Minimum is 4.
- `clk  in  1`: system clock (50 MHz on board).
- `n_rst  in  1`: reset. It is **synchronous and active-high**; the legacy name is kept. High at a rising `clk` edge resets the block.
- `TX_DATA  in  8`: byte to transmit. Sampled only at the launch edge.
- `tx_send  in  1`: send request. Active-low and synchronous to `clk`; idle high.
- `rx  in  1`: serial input. Asynchronous; idle high.
- `tx  out  1`: serial output. Idle high.
- `parity_error  out  1`: parity result of the last accepted frame. Held until the next frame completes.
- `heard_bit_out  out  1`: one-cycle strobe when a frame is accepted.
- `RX_DATA  out  8`: last accepted byte.
- `DISPLAYS  out  14`: `{seg(RX_DATA[7:4]), seg(RX_DATA[3:0])}`. Each digit is 7 bits, gfedcba order, active-low.

## Operation
- Frame format: start bit (0), 8 data bits LSB first, even-parity bit (XOR of the data), stop bit (1).
- **TX FSM** (states IDLE, START, DATA, PARITY, STOP):
  - A launch occurs on a high→low transition of `tx_send` (previous-cycle register) while in IDLE.
  - At launch, `TX_DATA` is latched and the FSM enters START.
  - Each state lasts `CLKS_PER_BIT` cycles. DATA iterates over 8 bits. STOP returns to IDLE.
  - Transitions on `tx_send` while not in IDLE are ignored.
  - Holding `tx_send` low produces exactly one frame.
  - `tx` is a registered output.
- **RX path**: `rx` passes through a 2-flop synchronizer. RX FSM states are IDLE, START, DATA, PARITY, STOP.
  - A falling edge of the synchronized `rx` in IDLE enters START.
  - At half a bit the start bit is re-checked. If it is high, this is a glitch and the FSM returns to IDLE.
  - Data, parity and stop are sampled at bit centres, every `CLKS_PER_BIT` cycles after the start-bit centre.
  - If the stop bit is 1, at the stop-bit centre: `RX_DATA` is updated, `parity_error` = received parity ≠ XOR(data), `heard_bit_out` = 1 for one cycle, then IDLE.
  - If the stop bit is 0 (framing error): outputs are unchanged, no strobe, and the FSM returns to IDLE after `rx` is high.
- TX and RX are fully independent; simultaneous activity is legal.
- `DISPLAYS` is combinational from `RX_DATA`. Hex font: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (7-bit hex values).

## Timing
- Reset values: `tx`=1, `RX_DATA`=0, `parity_error`=0, `heard_bit_out`=0, so `DISPLAYS`=14'h2040 ("00"). Both FSMs go to IDLE and counters clear.
- Reset asserted mid-frame aborts the frame; `tx` is 1 from the next edge.
- TX latency: `tx` falls on the clock edge after the edge that samples `tx_send`=0 with previous value 1.
  - Start bit is `CLKS_PER_BIT` cycles; the whole frame is 11×`CLKS_PER_BIT` cycles.
  - The next launch is possible the cycle after STOP ends.
- RX latency: `heard_bit_out` asserts 2 sync cycles + 10.5 bit times after the `rx` falling edge, ±1 cycle.

## Configuration
- `UART_PARITY_EN` defined (default build): 11-bit frame as above.
- Undefined: 8N1 10-bit frame. No parity bit is sent or expected, PARITY states are removed, and `parity_error` is tied to 0.

## Structure
- Package `uart_pkg`:
  - TX/RX state typedef.
  - Frame constants: `DATA_BITS`=8, default `CLKS_PER_BIT`.
  - Seven-segment font constant array.
- Sub-module `seg7_hex`: 4-bit in, 7-bit active-low out. Instantiated twice.
- TX and RX are separate always-blocks in the top module.

## Test plan
Run with `CLKS_PER_BIT`=8 and `rx` looped back from `tx` unless stated.
- Reset only → `tx`=1, `RX_DATA`=00, `DISPLAYS`=14'h2040, no strobe.
- `TX_DATA`=0xAE, pulse `tx_send` low:
  - `tx` bits are 0,0,1,1,1,0,1,0,1,1,1 (start, data LSB first, parity=1, stop), 8 cycles each.
  - Then `RX_DATA`=AE, one-cycle `heard_bit_out`, `parity_error`=0, `DISPLAYS`={08,06}.
- `TX_DATA`=0xAF, then reset, then send → parity bit 0, `RX_DATA`=AF, `DISPLAYS`={08,0E}.
- Drive `rx` directly with 0x55 and parity bit 1 (wrong) → `RX_DATA`=55, `parity_error`=1, strobe asserted.
- Hold `tx_send` low for 30 bit times → exactly one frame. A 2-cycle low glitch on `rx` → no strobe, RX returns to IDLE.
- Assert `n_rst` during TX data bit 3 → `tx`=1 next edge and no frame completes. RX framing error (stop=0) → no strobe and `RX_DATA` unchanged.
